signed_extender: RTL and testbench
==================================

Name: signed_extender

Overview:
RV32I immediate generator for the single-cycle core's decode stage. From one 32-bit instruction word it produces the sign-extended I and S immediates, the U immediate, and the PC-relative targets for SB (branch) and UJ (jal). All five results come out together from one output register bank, so each result is available one cycle after its inputs.

Parameters:
XLEN, 32, data/address width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
Instruction  input  32  instruction word; opcode bits [6:0] are ignored
PC  input  32  address of the instruction
in_valid  input  1  Instruction/PC are valid this cycle
out_valid  output  1  outputs hold results for the inputs captured on the previous edge
output_extended_I_type  output  32  sext(Instruction[31:20])
output_extended_S_type  output  32  sext({Instruction[31:25], Instruction[11:7]})
output_extended_SB_type  output  32  PC + sext({I[31], I[7], I[30:25], I[11:8], 1'b0})
output_extended_U_type  output  32  {Instruction[31:12], 12'b0}
output_extended_UJ_type  output  32  PC + sext({I[31], I[19:12], I[20], I[30:21], 1'b0})

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset: on any rising edge with rst=1, all five outputs and out_valid are set to 0. This overrides in_valid.
- Latency: fixed 1 cycle. On the edge that samples in_valid=1, all five outputs update at once and out_valid becomes 1.
- If in_valid=0 on an edge: outputs hold their previous values and out_valid becomes 0. There is no backpressure.
- Sign extension: bit 31 of Instruction is the sign for every immediate.
  - I and S: 12-bit fields extended to 32 bits.
  - B: 13-bit value, bit 0 always 0.
  - J: 21-bit value, bit 0 always 0.
- U: no extension; the low 12 bits are always 0.
- SB/UJ addition: 32-bit modulo-2^32, carry discarded. For example, PC=0xFFFFFFF0 plus 0x10 gives 0x00000000. No overflow flag.
- All five immediates are computed regardless of opcode; the datapath selects the one it needs.
- Reset asserted mid-stream: the in-flight result is discarded and out_valid=0. The first valid input after rst deasserts appears on the following edge.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN;
  - an imm_type_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J);
  - pure functions imm_i, imm_s, imm_b, imm_u and imm_j (32-bit instruction in, 32-bit immediate out).
- One sub-module, imm_decode: purely combinational bit-slicing and sign extension, no PC. The top adds the PC adders and the output register bank.

Test Plan:
- Reset: rst=1 for 2 edges with arbitrary inputs -> all outputs 0, out_valid=0.
- Instruction=0x80000000, PC=0, in_valid=1 -> next cycle:
  - I=S=0xFFFFF800, SB=0xFFFFF000;
  - U=0x80000000, UJ=0xFFF00000, out_valid=1.
- Instruction=0x8000000F, PC=0 -> same outputs as the previous case, proving opcode bits are ignored.
- Instruction=0xFFFFFFFF, PC=0 -> I=S=0xFFFFFFFF, SB=0xFFFFFFFE, U=0xFFFFF000, UJ=0xFFFFFFFE.
- Instruction=0x8F000080, PC=0x100 -> I=0xFFFFF8F0, S=0xFFFFF8E1, SB=0xFFFFF9E0, U=0x8F000000, UJ=0xFFF001F0.
- Wrap and hold:
  - Instruction=0x00000800, PC=0xFFFFFFF0 -> SB=0x00000000, S=0x00000010, I=0, U=0, UJ=0xFFFFFFF0.
  - Then drive in_valid=0 -> outputs hold, out_valid=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: data width, immediate kinds and pure immediate
// extraction functions. Every function takes a full instruction word and
// returns the sign-extended (or, for U, zero-filled) 32-bit immediate.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    // I-type: instr[31:20], sign-extended.
    function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    // S-type: store offset split across instr[31:25] and instr[11:7].
    function automatic logic [XLEN-1:0] imm_s(input logic [XLEN-1:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    // B-type: 13-bit branch offset, bit 0 always zero.
    function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // U-type: upper 20 bits, low 12 bits zero.
    function automatic logic [XLEN-1:0] imm_u(input logic [XLEN-1:0] instr);
        return {instr[31:12], 12'h000};
    endfunction

    // J-type: 21-bit jump offset, bit 0 always zero.
    function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: slices and sign-extends all five RV32I
// immediates from one instruction word. No PC involvement.
// Ports:
//   instr     - instruction word (opcode bits are not looked at)
//   imm_i_c   - I immediate
//   imm_s_c   - S immediate
//   imm_b_c   - B offset (not yet PC-relative)
//   imm_u_c   - U immediate
//   imm_j_c   - J offset (not yet PC-relative)
module imm_decode
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm_i_c,
    output logic [XLEN-1:0] imm_s_c,
    output logic [XLEN-1:0] imm_b_c,
    output logic [XLEN-1:0] imm_u_c,
    output logic [XLEN-1:0] imm_j_c
);

    always_comb begin
        imm_i_c = imm_i(instr);
        imm_s_c = imm_s(instr);
        imm_b_c = imm_b(instr);
        imm_u_c = imm_u(instr);
        imm_j_c = imm_j(instr);
    end

endmodule

// File: rtl/signed_extender.sv
// RV32I immediate generator for decode. Produces I/S/U immediates and the
// PC-relative branch (SB) and jal (UJ) targets from one registered bank,
// one cycle after in_valid.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   Instruction, PC          - instruction word and its address
//   in_valid                 - inputs valid this cycle
//   out_valid                - outputs hold results of the previous edge's inputs
//   output_extended_*_type   - registered immediates / targets
module signed_extender
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] Instruction,
    input  logic [XLEN-1:0] PC,
    input  logic            in_valid,
    output logic            out_valid,
    output logic [XLEN-1:0] output_extended_I_type,
    output logic [XLEN-1:0] output_extended_S_type,
    output logic [XLEN-1:0] output_extended_SB_type,
    output logic [XLEN-1:0] output_extended_U_type,
    output logic [XLEN-1:0] output_extended_UJ_type
);

    logic [XLEN-1:0] imm_i_c;
    logic [XLEN-1:0] imm_s_c;
    logic [XLEN-1:0] imm_b_c;
    logic [XLEN-1:0] imm_u_c;
    logic [XLEN-1:0] imm_j_c;
    logic [XLEN-1:0] target_b_c;
    logic [XLEN-1:0] target_j_c;

    imm_decode u_imm_decode (
        .instr   (Instruction),
        .imm_i_c (imm_i_c),
        .imm_s_c (imm_s_c),
        .imm_b_c (imm_b_c),
        .imm_u_c (imm_u_c),
        .imm_j_c (imm_j_c)
    );

    // PC-relative targets; modulo 2^XLEN, carry dropped.
    always_comb begin
        target_b_c = XLEN'(PC + imm_b_c);
        target_j_c = XLEN'(PC + imm_j_c);
    end

    // Output bank: reset clears, valid loads, otherwise hold data and drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid               <= 1'b0;
            output_extended_I_type  <= '0;
            output_extended_S_type  <= '0;
            output_extended_SB_type <= '0;
            output_extended_U_type  <= '0;
            output_extended_UJ_type <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                output_extended_I_type  <= imm_i_c;
                output_extended_S_type  <= imm_s_c;
                output_extended_SB_type <= target_b_c;
                output_extended_U_type  <= imm_u_c;
                output_extended_UJ_type <= target_j_c;
            end
        end
    end

endmodule

// File: tb/tb_signed_extender.sv
// Directed self-checking bench for signed_extender. Each task drives one
// scenario and compares valid plus all five outputs against hand-computed values.
module tb_signed_extender;

    typedef logic [31:0] res_t [5];

    logic        clk;
    logic        rst;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        in_valid;
    logic        out_valid;
    logic [31:0] out_i;
    logic [31:0] out_s;
    logic [31:0] out_sb;
    logic [31:0] out_u;
    logic [31:0] out_uj;

    int checks   = 0;
    int failures = 0;
    string names [5] = '{"I", "S", "SB", "U", "UJ"};

    signed_extender dut (
        .clk                     (clk),
        .rst                     (rst),
        .Instruction             (Instruction),
        .PC                      (PC),
        .in_valid                (in_valid),
        .out_valid               (out_valid),
        .output_extended_I_type  (out_i),
        .output_extended_S_type  (out_s),
        .output_extended_SB_type (out_sb),
        .output_extended_U_type  (out_u),
        .output_extended_UJ_type (out_uj)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc);
        @(negedge clk);
        rst         = r;
        in_valid    = v;
        Instruction = ins;
        PC          = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_t got;
        res_t exp;
        step(1'b1, 1'b1, 32'hDEADBEEF, 32'h1234_5678);
        step(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFF_FFF0);
        got = '{out_i, out_s, out_sb, out_u, out_uj};
        exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset.valid got=%b exp=0", out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                failures++;
                $display("FAIL reset.%s got=%h exp=%h", names[k], got[k], exp[k]);
            end
        end
    endtask

    // Single valid vector followed by a full comparison.
    task automatic test_vector(input string tag, input logic [31:0] ins,
                               input logic [31:0] pc, input res_t exp);
        res_t got;
        step(1'b0, 1'b1, ins, pc);
        got = '{out_i, out_s, out_sb, out_u, out_uj};
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s.valid got=%b exp=1", tag, out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                failures++;
                $display("FAIL %s.%s got=%h exp=%h", tag, names[k], got[k], exp[k]);
            end
        end
    endtask

    task automatic test_sign_min();
        test_vector("sign_min", 32'h8000_0000, 32'h0,
            '{32'hFFFFF800, 32'hFFFFF800, 32'hFFFFF000, 32'h80000000, 32'hFFF00000});
    endtask

    task automatic test_opcode_ignored();
        test_vector("opcode_ignored", 32'h8000_000F, 32'h0,
            '{32'hFFFFF800, 32'hFFFFF800, 32'hFFFFF000, 32'h80000000, 32'hFFF00000});
    endtask

    task automatic test_all_ones();
        test_vector("all_ones", 32'hFFFF_FFFF, 32'h0,
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFF000, 32'hFFFFFFFE});
    endtask

    task automatic test_mixed();
        test_vector("mixed", 32'h8F00_0080, 32'h0000_0100,
            '{32'hFFFFF8F0, 32'hFFFFF8E1, 32'hFFFFF9E0, 32'h8F000000, 32'hFFF001F0});
    endtask

    // Carry-out of the target adders is dropped, then outputs hold on in_valid=0.
    task automatic test_wrap_hold();
        res_t got;
        res_t exp;
        exp = '{32'h00000000, 32'h00000010, 32'h00000000, 32'h00000000, 32'hFFFFFFF0};
        test_vector("wrap", 32'h0000_0800, 32'hFFFF_FFF0, exp);
        step(1'b0, 1'b0, 32'h1234_5678, 32'h0000_4000);
        got = '{out_i, out_s, out_sb, out_u, out_uj};
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold.valid got=%b exp=0", out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                failures++;
                $display("FAIL hold.%s got=%h exp=%h", names[k], got[k], exp[k]);
            end
        end
    endtask

    // Two consecutive valid inputs: each edge reflects its own input.
    task automatic test_back_to_back();
        // imm field 0x001 -> I=1, J: instr[20]=1 -> offset 0x800
        test_vector("b2b_0", 32'h0010_0000, 32'h0000_1000,
            '{32'h00000001, 32'h00000000, 32'h00001000, 32'h00100000, 32'h00001800});
        // instr[7]=1 sets B bit 11; bits 11:8 = 0xF -> S low=0x1F, B=0x81E
        test_vector("b2b_1", 32'h0000_0F80, 32'h0000_0010,
            '{32'h00000000, 32'h0000001F, 32'h0000082E, 32'h00000000, 32'h00000010});
    endtask

    // Reset during a valid stream discards the in-flight result.
    task automatic test_reset_midstream();
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        step(1'b1, 1'b1, 32'h8000_0000, 32'h0);
        checks++;
        if (out_valid !== 1'b0 || out_i !== 32'h0 || out_uj !== 32'h0) begin
            failures++;
            $display("FAIL midreset got v=%b I=%h UJ=%h exp v=0 I=0 UJ=0",
                     out_valid, out_i, out_uj);
        end
        test_vector("after_reset", 32'h8F00_0080, 32'h0000_0100,
            '{32'hFFFFF8F0, 32'hFFFFF8E1, 32'hFFFFF9E0, 32'h8F000000, 32'hFFF001F0});
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        Instruction = 32'h0;
        PC          = 32'h0;
        test_reset();
        test_sign_min();
        test_opcode_ignored();
        test_all_ones();
        test_mixed();
        test_wrap_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
